// File: rtl/commit_trace_queue.sv
// Retirement trace queue: compacts up to COMMITS commits plus one trap per cycle
// into a circular FIFO drained one record per valid/ready handshake.
// Optional statistics outputs: define COMMIT_TRACE_QUEUE_STATS_EN.
module commit_trace_queue #(
    parameter int COMMITS = 2,
    parameter int DEPTH   = 16,
    parameter int XLEN    = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [COMMITS-1:0]         in_valid,
    input  logic [COMMITS*XLEN-1:0]    in_pc,
    input  logic [COMMITS*32-1:0]      in_insn,
    input  logic [COMMITS-1:0]         in_wen,
    input  logic [COMMITS*5-1:0]       in_waddr,
    input  logic [COMMITS*XLEN-1:0]    in_wdata,
    input  logic                       trap_valid,
    input  logic [XLEN-1:0]            trap_cause,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_is_trap,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_insn,
    output logic                       out_wen,
    output logic [4:0]                 out_waddr,
    output logic [XLEN-1:0]            out_wdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
`ifdef COMMIT_TRACE_QUEUE_STATS_EN
    ,
    output logic [63:0]                stat_retired,
    output logic [31:0]                stat_traps,
    output logic [$clog2(DEPTH+1)-1:0] stat_peak
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic            m_trap  [DEPTH];
    logic [XLEN-1:0] m_pc    [DEPTH];
    logic [31:0]     m_insn  [DEPTH];
    logic            m_wen   [DEPTH];
    logic [4:0]      m_waddr [DEPTH];
    logic [XLEN-1:0] m_wdata [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] lane_addr [COMMITS];
    logic [PW-1:0] n_commits, trap_addr;
    logic [CW-1:0] pushes, space, count_next;
    logic          pop, accept;

    // Each valid lane lands at wr_ptr plus the number of valid older lanes.
    always_comb begin
        n_commits = '0;
        for (int i = 0; i < COMMITS; i++) begin
            lane_addr[i] = wr_ptr + n_commits;
            if (in_valid[i]) n_commits = n_commits + PW'(1);
        end
        trap_addr  = wr_ptr + n_commits;
        pushes     = CW'(n_commits) + CW'(trap_valid);
        pop        = out_valid && out_ready;
        space      = CW'(DEPTH) - count + CW'(pop);
        accept     = (pushes <= space);
        count_next = accept ? (count + pushes - CW'(pop)) : (count - CW'(pop));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (accept) wr_ptr <= wr_ptr + PW'(pushes);
            else        overflow <= 1'b1;
            count <= count_next;
        end
    end

    // Entry storage carries no reset; a dropped group writes nothing.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int i = 0; i < COMMITS; i++) begin
                if (in_valid[i]) begin
                    m_trap[lane_addr[i]]  <= 1'b0;
                    m_pc[lane_addr[i]]    <= in_pc[i*XLEN +: XLEN];
                    m_insn[lane_addr[i]]  <= in_insn[i*32 +: 32];
                    m_wen[lane_addr[i]]   <= in_wen[i];
                    m_waddr[lane_addr[i]] <= in_waddr[i*5 +: 5];
                    m_wdata[lane_addr[i]] <= in_wdata[i*XLEN +: XLEN];
                end
            end
            if (trap_valid) begin
                m_trap[trap_addr]  <= 1'b1;
                m_pc[trap_addr]    <= '0;
                m_insn[trap_addr]  <= '0;
                m_wen[trap_addr]   <= 1'b0;
                m_waddr[trap_addr] <= '0;
                m_wdata[trap_addr] <= trap_cause;
            end
        end
    end

    assign in_ready    = (CW'(DEPTH) - count) >= CW'(COMMITS + 1);
    assign out_valid   = (count != '0);
    assign out_is_trap = m_trap[rd_ptr];
    assign out_pc      = m_pc[rd_ptr];
    assign out_insn    = m_insn[rd_ptr];
    assign out_wen     = m_wen[rd_ptr];
    assign out_waddr   = m_waddr[rd_ptr];
    assign out_wdata   = m_wdata[rd_ptr];

`ifdef COMMIT_TRACE_QUEUE_STATS_EN
    logic [64:0] retired_sum;
    assign retired_sum = {1'b0, stat_retired} + 65'(n_commits);

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_retired <= '0;
            stat_traps   <= '0;
            stat_peak    <= '0;
        end else begin
            if (accept) begin
                stat_retired <= retired_sum[64] ? '1 : retired_sum[63:0];
                if (trap_valid && stat_traps != '1) stat_traps <= stat_traps + 32'd1;
            end
            if (count_next > stat_peak) stat_peak <= count_next;
        end
    end
`endif
endmodule

// File: doc/commit_trace_queue.md
Name: commit_trace_queue

Overview:
- Sits between the core's per-cycle retirement ports and the co-simulation checker.
- Captures up to COMMITS retirements plus one trap per cycle and compacts them in program order into a circular FIFO.
- Drains entries one per cycle over a valid/ready stream, so the checker performs exactly one commit/judge/trap call per handshake.
- Decouples superscalar retirement bursts from the single-step reference model.

Parameters:
- COMMITS, 2, retirement lanes per cycle; lane 0 is the oldest.
- DEPTH, 16, FIFO entries; power of two, at least COMMITS+1.
- XLEN, 64, PC and data width.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  COMMITS  per-lane retire valid.
- in_pc  input  COMMITS*XLEN  packed PCs; lane i at bits [i*XLEN +: XLEN].
- in_insn  input  COMMITS*32  packed instruction words.
- in_wen  input  COMMITS  lane writes a register.
- in_waddr  input  COMMITS*5  packed destination register indices.
- in_wdata  input  COMMITS*XLEN  packed writeback data.
- trap_valid  input  1  trap raised this cycle.
- trap_cause  input  XLEN  trap cause.
- in_ready  output  1  free slots >= COMMITS+1 (advisory; the core may ignore it).
- out_valid  output  1  head entry present.
- out_ready  input  1  checker consumes head.
- out_is_trap  output  1  head is a trap record.
- out_pc  output  XLEN  head PC; 0 for traps.
- out_insn  output  32  head instruction word.
- out_wen  output  1  head register-write flag.
- out_waddr  output  5  head destination register.
- out_wdata  output  XLEN  head write data, or the cause for traps.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow  output  1  sticky drop flag.

Behaviour:
- Reset (synchronous, active-high): read/write pointers = 0, count = 0, overflow = 0, out_valid = 0, in_ready = 1. All entry contents are don't-care. Reset applied mid-drain discards all entries on the next edge.
- Group formation: pushes = popcount(in_valid) + trap_valid.
  - Valid lanes are written at consecutive addresses wr_ptr, wr_ptr+1, … in ascending lane order, skipping invalid lanes. Example: in_valid = 2'b10 writes lane 1 at wr_ptr.
  - The trap record is written after the cycle's commits, with out_pc = 0, out_insn = 0, out_wen = 0, out_wdata = trap_cause.
- Pop: occurs when out_valid && out_ready. rd_ptr advances by 1. out_* is combinational from the head entry; there is no bubble between consecutive pops.
- Free-space check: space = DEPTH - count + pop.
  - If pushes <= space: the whole group is written, wr_ptr += pushes, count' = count + pushes - pop.
  - Otherwise the entire group is dropped (nothing is partially written), overflow is set to 1 and stays 1 until reset, and the pop still proceeds.
- Simultaneous push and pop at count == DEPTH: the pop frees a slot in the same cycle, so one push is accepted.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count disambiguates full from empty.
- Empty: out_valid = 0; out_ready is ignored.
- Latency: an entry written at edge N is visible on out_* after edge N. No bypass from inputs to outputs.
- in_wen is stored as given. A lane with in_valid = 0 is ignored regardless of its other fields.

Optional Feature:
- Macro COMMIT_TRACE_QUEUE_STATS_EN.
- When defined, the block adds outputs:
  - stat_retired (64): count of accepted commit records, excluding traps and dropped groups.
  - stat_traps (32): count of accepted trap records.
  - stat_peak (same width as count): maximum count observed.
  - All three are cleared by reset; the counters saturate at their maximum value.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Single lane: after reset, drive lane 0 with pc=0x80000000, insn=0x00000013, out_ready=1 → out_valid the next cycle with matching pc/insn, count returns to 0 after one pop.
- Compaction: in_valid=2'b11 with pcs 0x100/0x104 and trap_valid=1 cause=0x2, out_ready=0 → count=3; draining yields 0x100, 0x104, then a trap record with out_wdata=0x2 and out_is_trap=1.
- Sparse lane: in_valid=2'b10, lane 1 pc=0x200, wen=1, waddr=5, wdata=0xDEAD → head pc=0x200, waddr=5, wdata=0xDEAD.
- Full and overflow: out_ready=0, push 2 entries per cycle for 8 cycles → count=16 and in_ready=0. A ninth push of 2 → count stays 16 and overflow=1. The same push with out_ready=1 → group dropped, count=15.
- Wrap: 40 cycles of random 0–2 pushes with out_ready toggling, without overflow → output order matches the scoreboard across pointer wrap.
- Reset mid-drain: with count=5, assert reset for 1 cycle → count=0, out_valid=0, overflow=0; a subsequent push works normally.
